repvgg_col_engine: RTL and testbench
====================================

# repvgg_col_engine

Parametrised column-wise convolution engine for the RepVGG accelerator. It generalises the fixed 56-row, 3x3-plus-1x1 PE arrangement into a single configurable unit. Per job it accumulates one output-channel column of HIT rows over up to CIN_MAX input channels. Mode is either 3x3 (vertical 3-tap per kernel column, zero-padded top and bottom) or 1x1, followed by bias, optional ReLU and saturation. It sits between the feature-map/weight buffers and the output par2ser stage, with valid/ready handshakes on both sides.

## Interface
- HIT, 56, rows per column (lanes)
- DW, 32, data/weight width, signed fixed point
- FW, 8, fraction bits (integer bits = DW-FW)
- CIN_MAX, 64, max input channels per job
- ACC_W, 2*DW+8, per-lane accumulator width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job start pulse, sampled in IDLE only
- cfg_mode  in  1  0 = 3x3, 1 = 1x1
- cfg_cin  in  $clog2(CIN_MAX+1)  input channels this job (0 treated as 1)
- cfg_relu  in  1  apply ReLU
- cfg_id_en  in  1  enable identity branch (used only with IDENTITY_EN)
- cfg_id_ch  in  $clog2(CIN_MAX)  input channel carrying identity
- bias  in  DW  bias, same Q format as data
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- fmap_i  in  HIT*DW  one input column, lane r = bits [r*DW +: DW]
- wht_i  in  3*DW  w0 (row above), w1 (centre), w2 (row below)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- data_o  out  HIT*DW  result column
- sat_o  out  1  at least one lane saturated (qualified by out_valid)
- busy  out  1  job in progress

## Operation
- States: IDLE, ACCUM, FINAL, OUT.
- IDLE: start=1 latches all cfg_* and bias, clears accumulators and counters, and moves to ACCUM.
- ACCUM: in_ready=1. Each accepted beat updates every lane: acc[r] += w0*x[r-1] + w1*x[r] + w2*x[r+1], with x[-1] = x[HIT] = 0. In 1x1 mode only w1*x[r] is added; w0 and w2 are ignored.
- Beat order in 3x3 mode: channel-major, kernel column kc = 0,1,2 within each channel. Counters ch and kc track position; total beats = 3*cin. In 1x1 mode, total beats = cin.
- The last beat moves the FSM to FINAL.
- Arithmetic:
  - Products are full 2*DW signed with 2*FW fraction bits, sign-extended to ACC_W.
  - The accumulator wraps modulo 2^ACC_W.
- FINAL (one cycle):
  - s = (acc + (bias <<< FW)) >>> FW, arithmetic shift (floor).
  - Saturate s to signed DW; set sat_o if any lane clipped.
  - If relu, negative results become 0, applied after saturation.
  - Register data_o and sat_o, then go to OUT.
- OUT: out_valid=1, and data_o/sat_o are held stable until out_ready=1. Then go to IDLE with busy=0.
- busy=1 in ACCUM, FINAL and OUT. start is ignored while busy.
- Reset, including mid-job: returns to IDLE immediately. Accumulators and counters clear; the partial job is discarded.

## Timing
- Reset values: in_ready=0, out_valid=0, data_o=0, sat_o=0, busy=0.
- start at cycle t: busy=1 and in_ready=1 from t+1.
- Throughput: one beat per cycle with no bubbles.
- Last beat accepted at cycle T: in_ready=0 at T+1, out_valid=1 at T+2.
- Next start is accepted at the earliest one cycle after the out_valid & out_ready handshake.
- in_ready is a pure function of state, with no combinational path from in_valid.

## Configuration
- IDENTITY_EN defined:
  - Applies when cfg_id_en=1, on the beat with ch == cfg_id_ch and (kc == 1 or 1x1 mode).
  - On that beat each lane additionally adds x[r] <<< FW, the RepVGG identity branch.
  - If cfg_id_ch >= cin, no identity is added.
- IDENTITY_EN undefined: the identity path is not built; cfg_id_en and cfg_id_ch are ignored.

## Test plan
(bench overrides HIT=4; default DW=32, FW=8)
- 1x1 scaling: cin=1, x=1.0 (256), w1=2.0 (512), bias=0.5 (128) -> all lanes 640, sat_o=0, out_valid two cycles after the beat.
- 3x3 padding: cin=1, three beats of x=1.0, all weights 1.0, bias 0 -> lanes {1536, 2304, 2304, 1536}.
- ReLU: 1x1, x=1.0, w1=-1.0 -> relu=1 gives 0; relu=0 gives 0xFFFFFF00.
- Saturation: 1x1, cin=4, x=0x7FFFFFFF, w1=127.0 -> all lanes 0x7FFFFFFF, sat_o=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles: data_o stays stable, in_ready=0, start is ignored.
  - Assert rst_n=0 mid-ACCUM: all outputs are 0 immediately, and a following clean job produces the correct result.
- IDENTITY_EN: 3x3, cin=2, cfg_id_ch=1, all x=1.0, weights 0 -> every lane 256. Without the macro -> 0.

Source files
------------

// File: rtl/repvgg_col_engine_if.sv
// Beat and result channels of the column engine: input column + weights
// upstream, saturated result column downstream, each with valid/ready.
interface repvgg_col_engine_if #(
    parameter int HIT = 56,
    parameter int DW  = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [HIT*DW-1:0]    fmap_i;
    logic [3*DW-1:0]      wht_i;
    logic                 out_valid;
    logic                 out_ready;
    logic [HIT*DW-1:0]    data_o;
    logic                 sat_o;

    modport master (
        output in_valid, fmap_i, wht_i, out_ready,
        input  in_ready, out_valid, data_o, sat_o
    );

    modport slave (
        input  in_valid, fmap_i, wht_i, out_ready,
        output in_ready, out_valid, data_o, sat_o
    );
endinterface

// File: rtl/repvgg_col_engine.sv
// Column-wise 3x3 / 1x1 convolution engine with bias, saturation and ReLU.
// Optional RepVGG identity branch is built when IDENTITY_EN is defined.
module repvgg_col_engine #(
    parameter int HIT     = 56,
    parameter int DW      = 32,
    parameter int FW      = 8,
    parameter int CIN_MAX = 64,
    parameter int ACC_W   = 2*DW+8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         cfg_mode,
    input  logic [$clog2(CIN_MAX+1)-1:0] cfg_cin,
    input  logic                         cfg_relu,
    input  logic                         cfg_id_en,
    input  logic [$clog2(CIN_MAX)-1:0]   cfg_id_ch,
    input  logic [DW-1:0]                bias,
    repvgg_col_engine_if.slave           bus,
    output logic                         busy
);
    localparam int CW = $clog2(CIN_MAX+1);
    localparam int IW = $clog2(CIN_MAX);

    typedef enum logic [1:0] {IDLE, ACCUM, FINAL, OUT} state_t;
    state_t state_reg, state_next;

    logic          mode_reg, relu_reg;
    logic [CW-1:0] cin_reg, ch_reg;
    logic [1:0]    kc_reg;
    logic [DW-1:0] bias_reg;
    logic          beat, last_beat, job_start, id_hit;
    logic [DW-1:0] w0_eff, w1, w2_eff;
    logic [ACC_W-1:0]  bias_ext;
    logic [HIT*DW-1:0] lane_res;
    logic [HIT-1:0]    lane_clip;

    assign job_start = (state_reg == IDLE) && start;
    assign beat      = (state_reg == ACCUM) && bus.in_valid;
    assign last_beat = beat && (ch_reg == cin_reg - CW'(1)) && (mode_reg || kc_reg == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (last_beat) state_next = FINAL;
            FINAL:   state_next = OUT;
            OUT:     if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_reg == ACCUM);
        bus.out_valid = (state_reg == OUT);
        busy          = (state_reg != IDLE);
    end

    // Channel-major beat position; kc only advances in 3x3 mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg <= 1'b0;
            relu_reg <= 1'b0;
            cin_reg  <= '0;
            bias_reg <= '0;
            ch_reg   <= '0;
            kc_reg   <= '0;
        end else if (job_start) begin
            mode_reg <= cfg_mode;
            relu_reg <= cfg_relu;
            cin_reg  <= (cfg_cin == '0) ? CW'(1) : cfg_cin;
            bias_reg <= bias;
            ch_reg   <= '0;
            kc_reg   <= '0;
        end else if (beat) begin
            if (mode_reg || kc_reg == 2'd2) begin
                kc_reg <= '0;
                ch_reg <= ch_reg + CW'(1);
            end else begin
                kc_reg <= kc_reg + 2'd1;
            end
        end
    end

`ifdef IDENTITY_EN
    logic          id_en_reg;
    logic [IW-1:0] id_ch_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_en_reg <= 1'b0;
            id_ch_reg <= '0;
        end else if (job_start) begin
            id_en_reg <= cfg_id_en;
            id_ch_reg <= cfg_id_ch;
        end
    end

    // ch never reaches cin, so an out-of-range id channel never fires.
    assign id_hit = id_en_reg && (CW'(id_ch_reg) == ch_reg) && (mode_reg || kc_reg == 2'd1);
`else
    logic unused_id;
    assign unused_id = ^{cfg_id_en, cfg_id_ch};
    assign id_hit    = 1'b0;
`endif

    assign w0_eff   = mode_reg ? '0 : bus.wht_i[0 +: DW];
    assign w1       = bus.wht_i[DW +: DW];
    assign w2_eff   = mode_reg ? '0 : bus.wht_i[2*DW +: DW];
    assign bias_ext = {{(ACC_W-DW-FW){bias_reg[DW-1]}}, bias_reg, {FW{1'b0}}};

    genvar gi;
    generate
        for (gi = 0; gi < HIT; gi++) begin : g_lane
            logic [DW-1:0]     x_up, x_mid, x_dn, sat_val;
            logic [2*DW-1:0]   p0, p1, p2;
            logic [ACC_W-1:0]  id_term, term, acc_reg, sum;
            logic signed [ACC_W-1:0] s;
            logic              clip;

            assign x_mid = bus.fmap_i[gi*DW +: DW];
            if (gi == 0) begin : g_top
                assign x_up = '0;
            end else begin : g_up
                assign x_up = bus.fmap_i[(gi-1)*DW +: DW];
            end
            if (gi == HIT-1) begin : g_bot
                assign x_dn = '0;
            end else begin : g_dn
                assign x_dn = bus.fmap_i[(gi+1)*DW +: DW];
            end

            // Low 2*DW bits of the widened product equal the signed product.
            assign p0 = {{DW{x_up[DW-1]}},  x_up}  * {{DW{w0_eff[DW-1]}}, w0_eff};
            assign p1 = {{DW{x_mid[DW-1]}}, x_mid} * {{DW{w1[DW-1]}},     w1};
            assign p2 = {{DW{x_dn[DW-1]}},  x_dn}  * {{DW{w2_eff[DW-1]}}, w2_eff};
            assign id_term = id_hit ? {{(ACC_W-DW-FW){x_mid[DW-1]}}, x_mid, {FW{1'b0}}} : '0;
            assign term = {{(ACC_W-2*DW){p0[2*DW-1]}}, p0}
                        + {{(ACC_W-2*DW){p1[2*DW-1]}}, p1}
                        + {{(ACC_W-2*DW){p2[2*DW-1]}}, p2}
                        + id_term;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)         acc_reg <= '0;
                else if (job_start) acc_reg <= '0;
                else if (beat)      acc_reg <= acc_reg + term;
            end

            assign sum  = acc_reg + bias_ext;
            assign s    = $signed(sum) >>> FW;
            assign clip = !((&s[ACC_W-1:DW-1]) || !(|s[ACC_W-1:DW-1]));
            assign sat_val = clip ? (s[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                                  : s[DW-1:0];
            assign lane_res[gi*DW +: DW] = (relu_reg && sat_val[DW-1]) ? '0 : sat_val;
            assign lane_clip[gi] = clip;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_o <= '0;
            bus.sat_o  <= 1'b0;
        end else if (state_reg == FINAL) begin
            bus.data_o <= lane_res;
            bus.sat_o  <= |lane_clip;
        end
    end
endmodule

// File: tb/tb_repvgg_col_engine.sv
// Randomised and directed checks of repvgg_col_engine (HIT=4) against a
// per-lane arithmetic reference model; define IDENTITY_EN to cover the identity branch.
module tb_repvgg_col_engine;
    localparam int HIT = 4;
    localparam int DW  = 32;

    logic       clk = 1'b0;
    logic       rst_n, start, cfg_mode, cfg_relu, cfg_id_en, busy;
    logic [6:0] cfg_cin;
    logic [5:0] cfg_id_ch;
    logic [31:0] bias;

    repvgg_col_engine_if #(.HIT(HIT), .DW(DW)) bus ();

    repvgg_col_engine #(.HIT(HIT), .DW(DW), .FW(8), .CIN_MAX(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode),
        .cfg_cin(cfg_cin), .cfg_relu(cfg_relu), .cfg_id_en(cfg_id_en),
        .cfg_id_ch(cfg_id_ch), .bias(bias), .bus(bus), .busy(busy)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int errs = 0;
    int job_no = 0;
    logic [31:0] bx [0:191][0:3];
    logic [31:0] bw [0:191][0:2];
    logic [31:0] exp_lane [0:3];
    bit          exp_sat;
    logic [31:0] got [0:3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        vec++;
        if (obs !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic signed [71:0] sx(input logic [31:0] v);
        return {{40{v[31]}}, v};
    endfunction

    function automatic logic [31:0] rnd32();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'($urandom_range(0, 8191)) - 32'd4096;
    endfunction

    // Reference: direct per-lane sum of the convolution over all beats.
    task automatic model(input bit mode, input int cin, input bit relu, input bit id_en,
                         input int id_ch, input logic [31:0] bias_v);
        int ce, nb, ch, kc;
        logic signed [71:0] acc, s, xu, xd;
        logic signed [71:0] maxv, minv;
        maxv = 72'sd2147483647;
        minv = -72'sd2147483648;
        ce = (cin == 0) ? 1 : cin;
        nb = mode ? ce : 3 * ce;
        exp_sat = 1'b0;
        for (int r = 0; r < HIT; r++) begin
            acc = '0;
            for (int b = 0; b < nb; b++) begin
                ch = mode ? b : b / 3;
                kc = mode ? 1 : b % 3;
                xu = (r > 0)     ? sx(bx[b][r-1]) : 72'sd0;
                xd = (r < HIT-1) ? sx(bx[b][r+1]) : 72'sd0;
                if (mode) acc = acc + sx(bx[b][r]) * sx(bw[b][1]);
                else      acc = acc + xu * sx(bw[b][0]) + sx(bx[b][r]) * sx(bw[b][1]) + xd * sx(bw[b][2]);
`ifdef IDENTITY_EN
                if (id_en && id_ch < ce && ch == id_ch && kc == 1)
                    acc = acc + sx(bx[b][r]) * 72'sd256;
`endif
            end
            s = (acc + sx(bias_v) * 72'sd256) >>> 8;
            if (s > maxv)      begin exp_lane[r] = 32'h7FFFFFFF; exp_sat = 1'b1; end
            else if (s < minv) begin exp_lane[r] = 32'h80000000; exp_sat = 1'b1; end
            else               exp_lane[r] = s[31:0];
            if (relu && exp_lane[r][31]) exp_lane[r] = 32'd0;
        end
    endtask

    task automatic drive_beat(input int b);
        for (int r = 0; r < HIT; r++) bus.fmap_i[r*32 +: 32] = bx[b][r];
        for (int k = 0; k < 3; k++)   bus.wht_i[k*32 +: 32]  = bw[b][k];
    endtask

    task automatic run_job(input string name, input bit mode, input int cin, input bit relu,
                           input bit id_en, input int id_ch, input logic [31:0] bias_v,
                           input int hold, input bit gaps);
        int ce, nb, b, guard;
        ce = (cin == 0) ? 1 : cin;
        nb = mode ? ce : 3 * ce;
        model(mode, cin, relu, id_en, id_ch, bias_v);
        @(posedge clk); #1;
        cfg_mode = mode; cfg_cin = 7'(cin); cfg_relu = relu;
        cfg_id_en = id_en; cfg_id_ch = 6'(id_ch); bias = bias_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, ":busy_start"}, 64'(busy), 64'd1);
        chk({name, ":in_ready_start"}, 64'(bus.in_ready), 64'd1);
        b = 0;
        guard = 0;
        while (b < nb && guard < 2000) begin
            if (gaps && $urandom_range(0, 3) == 0) bus.in_valid = 1'b0;
            else begin bus.in_valid = 1'b1; drive_beat(b); end
            @(posedge clk); #1;
            if (bus.in_valid) b++;
            guard++;
        end
        bus.in_valid = 1'b0;
        chk({name, ":beats"}, 64'(b), 64'(nb));
        chk({name, ":in_ready_after"}, 64'(bus.in_ready), 64'd0);
        chk({name, ":out_valid_early"}, 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        chk({name, ":out_valid"}, 64'(bus.out_valid), 64'd1);
        for (int k = 0; k < hold; k++) begin
            start = 1'b1;
            @(posedge clk); #1;
            chk({name, ":hold_valid"}, 64'(bus.out_valid), 64'd1);
            chk({name, ":hold_in_ready"}, 64'(bus.in_ready), 64'd0);
            for (int r = 0; r < HIT; r++)
                chk({name, ":hold_lane"}, 64'(bus.data_o[r*32 +: 32]), 64'(exp_lane[r]));
        end
        start = 1'b0;
        for (int r = 0; r < HIT; r++) begin
            got[r] = bus.data_o[r*32 +: 32];
            chk({name, ":lane"}, 64'(got[r]), 64'(exp_lane[r]));
        end
        chk({name, ":sat"}, 64'(bus.sat_o), 64'(exp_sat));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({name, ":busy_end"}, 64'(busy), 64'd0);
        chk({name, ":out_valid_end"}, 64'(bus.out_valid), 64'd0);
        $display("job %0d %s mode=%0d cin=%0d relu=%0d lanes=%h %h %h %h sat=%0d",
                 job_no, name, mode, cin, relu, got[0], got[1], got[2], got[3], bus.sat_o);
        job_no++;
    endtask

    task automatic fill(input int nb, input logic [31:0] x, input logic [31:0] w0,
                        input logic [31:0] w1, input logic [31:0] w2);
        for (int b = 0; b < nb; b++) begin
            for (int r = 0; r < HIT; r++) bx[b][r] = x;
            bw[b][0] = w0; bw[b][1] = w1; bw[b][2] = w2;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] id_want;
        rst_n = 1'b0; start = 1'b0; cfg_mode = 1'b0; cfg_cin = '0; cfg_relu = 1'b0;
        cfg_id_en = 1'b0; cfg_id_ch = '0; bias = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.fmap_i = '0; bus.wht_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst:in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst:out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst:data_o", 64'(bus.data_o[63:0]), 64'd0);
        chk("rst:data_o_hi", 64'(bus.data_o[127:64]), 64'd0);
        chk("rst:sat_o", 64'(bus.sat_o), 64'd0);
        chk("rst:busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        fill(1, 32'd256, $urandom, 32'd512, $urandom);
        run_job("scale", 1'b1, 1, 1'b0, 1'b0, 0, 32'd128, 0, 1'b0);
        for (int r = 0; r < HIT; r++) chk("scale:const", 64'(got[r]), 64'd640);

        fill(3, 32'd256, 32'd256, 32'd256, 32'd256);
        run_job("pad3x3", 1'b0, 1, 1'b0, 1'b0, 0, 32'd0, 0, 1'b0);
        chk("pad3x3:l0", 64'(got[0]), 64'd1536);
        chk("pad3x3:l1", 64'(got[1]), 64'd2304);
        chk("pad3x3:l2", 64'(got[2]), 64'd2304);
        chk("pad3x3:l3", 64'(got[3]), 64'd1536);

        fill(1, 32'd256, 32'd0, 32'hFFFFFF00, 32'd0);
        run_job("relu_on", 1'b1, 1, 1'b1, 1'b0, 0, 32'd0, 0, 1'b0);
        chk("relu_on:const", 64'(got[2]), 64'd0);
        run_job("relu_off", 1'b1, 1, 1'b0, 1'b0, 0, 32'd0, 0, 1'b0);
        chk("relu_off:const", 64'(got[2]), 64'hFFFFFF00);

        fill(4, 32'h7FFFFFFF, 32'd0, 32'd32512, 32'd0);
        run_job("sat", 1'b1, 4, 1'b0, 1'b0, 0, 32'd0, 5, 1'b0);
        chk("sat:const", 64'(got[1]), 64'h7FFFFFFF);
        chk("sat:flag", 64'(bus.sat_o), 64'd1);

        fill(6, 32'd256, 32'd0, 32'd0, 32'd0);
`ifdef IDENTITY_EN
        id_want = 32'd256;
`else
        id_want = 32'd0;
`endif
        run_job("identity", 1'b0, 2, 1'b0, 1'b1, 1, 32'd0, 0, 1'b0);
        for (int r = 0; r < HIT; r++) chk("identity:const", 64'(got[r]), 64'(id_want));

        // Reset in the middle of an accumulation, after a saturating result.
        fill(4, 32'h7FFFFFFF, 32'd0, 32'd32512, 32'd0);
        run_job("presat", 1'b1, 4, 1'b0, 1'b0, 0, 32'd0, 0, 1'b0);
        @(posedge clk); #1;
        cfg_mode = 1'b0; cfg_cin = 7'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b1; drive_beat(0);
        @(posedge clk); #1;
        drive_beat(1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst:in_ready", 64'(bus.in_ready), 64'd0);
        chk("midrst:out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst:busy", 64'(busy), 64'd0);
        chk("midrst:data_o", 64'(bus.data_o[63:0]), 64'd0);
        chk("midrst:sat_o", 64'(bus.sat_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fill(1, 32'd256, $urandom, 32'd512, $urandom);
        run_job("postrst", 1'b1, 1, 1'b0, 1'b0, 0, 32'd128, 0, 1'b0);
        for (int r = 0; r < HIT; r++) chk("postrst:const", 64'(got[r]), 64'd640);

        fill(1, 32'd512, 32'd0, 32'd256, 32'd0);
        run_job("cin0", 1'b1, 0, 1'b0, 1'b0, 0, 32'd0, 0, 1'b0);
        chk("cin0:const", 64'(got[0]), 64'd512);

        for (int j = 0; j < 24; j++) begin
            int cin;
            bit mode;
            cin  = $urandom_range(0, 6);
            mode = 1'($urandom_range(0, 1));
            for (int b = 0; b < 18; b++) begin
                for (int r = 0; r < HIT; r++) bx[b][r] = rnd32();
                for (int k = 0; k < 3; k++)   bw[b][k] = rnd32();
            end
            run_job("rand", mode, cin, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7), rnd32(), $urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
